// File: rtl/img_word_packer.sv
// Purpose: packs a PXL_W-bit pixel stream into 16*LANES-bit DMEM words (one 16-bit lane per pixel) and flags frame completion.
// Latency: a completed word reaches the DMEM write port two edges after its last pixel is accepted.
// Backpressure: a 2-word FIFO absorbs dmem_ready stalls; a word that completes while the FIFO is full is dropped and overflow is set.
module img_word_packer #(
    parameter int PIXELS    = 784,
    parameter int LANES     = 16,
    parameter int PXL_W     = 9,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  pxl_valid,
    input  logic [PXL_W-1:0]      pxl_data,
    input  logic                  dmem_ready,
    output logic                  dmem_wren,
    output logic [ADDR_W-1:0]     dmem_wraddr,
    output logic [16*LANES-1:0]   dmem_wrdata,
    output logic                  img_done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int WORD_W = 16 * LANES;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
    localparam logic [9:0]        LAST_PIX  = 10'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t              state;
    logic [9:0]          pix_cnt;
    logic [LIDX_W-1:0]   lane_idx;
    logic [ADDR_W-1:0]   word_idx;
    logic [WORD_W-1:0]   word_buf;

    // Two-entry word FIFO between the packer and the write port.
    logic [WORD_W-1:0]   fifo_dat  [2];
    logic [ADDR_W-1:0]   fifo_addr [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;

    logic                active;
    logic                arm;
    logic                abort;
    logic                accept;
    logic                word_cmp;
    logic                pop_en;
    logic                push_en;
    logic                drop;
    logic                flush;
    logic [WORD_W-1:0]   push_word;
    logic [ADDR_W-1:0]   push_addr;

    // Control decodes shared by the FSM, the FIFO and the lane buffer.
    always_comb begin
        active   = (state == FILL) || (state == DRAIN);
        arm      = ((state == IDLE) || (state == DONE)) && start && enable;
        abort    = active && !enable;
        accept   = (state == FILL) && enable && pxl_valid;
        word_cmp = accept && (lane_idx == LAST_LANE);
        pop_en   = active && enable && dmem_ready && (fifo_cnt != 2'd0);
        // A full FIFO that is popping this same edge still has room.
        push_en  = word_cmp && ((fifo_cnt != 2'd2) || pop_en);
        drop     = word_cmp && !push_en;
        flush    = arm || abort;
        push_addr = BASE + word_idx;
    end

    // Current word with the incoming pixel merged into its lane; stale lanes are never pushed.
    always_comb begin
        push_word = word_buf;
        push_word[{lane_idx, 4'b0000} +: 16] = {{(16 - PXL_W){1'b0}}, pxl_data};
    end

    // Lane buffer accumulates pixels of the word being assembled.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            word_buf <= '0;
        end else if (accept) begin
            word_buf <= push_word;
        end
    end

    // FIFO storage; contents are only read after being written.
    always_ff @(posedge CLOCK_50) begin
        if (push_en && !flush) begin
            fifo_dat[wr_ptr]  <= push_word;
            fifo_addr[wr_ptr] <= push_addr;
        end
    end

    // FIFO pointers and occupancy; flushed on arm and on abort.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (flush) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push_en) wr_ptr <= ~wr_ptr;
            if (pop_en)  rd_ptr <= ~rd_ptr;
            case ({push_en, pop_en})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Frame FSM with counters and all registered outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            lane_idx    <= '0;
            word_idx    <= '0;
            dmem_wren   <= 1'b0;
            dmem_wraddr <= '0;
            dmem_wrdata <= '0;
            img_done    <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dmem_wren <= pop_en;
            if (pop_en) begin
                dmem_wraddr <= fifo_addr[rd_ptr];
                dmem_wrdata <= fifo_dat[rd_ptr];
            end
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state    <= FILL;
                        pix_cnt  <= '0;
                        lane_idx <= '0;
                        word_idx <= '0;
                        overflow <= 1'b0;
                        img_done <= 1'b0;
                        busy     <= 1'b1;
                    end else if (!enable) begin
                        state    <= IDLE;
                        img_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        lane_idx <= lane_idx + 1'b1;
                        pix_cnt  <= pix_cnt + 10'd1;
                        if (word_cmp) word_idx <= word_idx + 1'b1;
                        if (drop)     overflow <= 1'b1;
                        if (pix_cnt == LAST_PIX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if ((fifo_cnt == 2'd0) && !dmem_wren) begin
                        // Wait out the final write strobe before declaring the frame done.
                        state    <= DONE;
                        busy     <= 1'b0;
                        img_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
